// File: rtl/ifstage_fetch_unit.sv
// Instruction fetch: owns PC, issues req/ack word reads, holds Instr until PC_LdEn (2-cycle zero-wait fetch).
// Optional ack watchdog under FETCH_TIMEOUT_EN; without it REQ waits for ack indefinitely.
module ifstage_fetch_unit #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       PC_Immed,
  input  logic              PC_sel,
  input  logic              PC_LdEn,
  output logic              IMem_Req,
  output logic [ADDR_W-1:0] IMem_Addr,
  input  logic              IMem_Ack,
  input  logic [31:0]       IMem_RdData,
  output logic [31:0]       Instr,
  output logic              Instr_valid,
  output logic [31:0]       PC,
  output logic              Fetch_busy,
  output logic              Fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_q;
  logic        vld_q;
  logic        req_q;
  logic        busy_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_q;
  logic             err_q;
  logic             tmo_hit;

  // Fires on the last permitted REQ cycle without an ack.
  assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  // Immediate is a word offset; the shift drops its top two bits (modulo-2^32 arithmetic).
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (PC_sel) begin
      pc_d = pc_d + (PC_Immed << 2);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      vld_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        REQ: begin
          if (IMem_Ack) begin
            instr_q <= IMem_RdData;
            vld_q   <= 1'b1;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tmo_hit) begin
            // Hand decode a NOP so it never stalls on a dead memory.
            err_q   <= 1'b1;
            instr_q <= 32'h0000_0000;
            vld_q   <= 1'b1;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= HOLD;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (PC_LdEn) begin
            pc_q    <= pc_d;
            vld_q   <= 1'b0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= REQ;
`ifdef FETCH_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign IMem_Req    = req_q;
  assign IMem_Addr   = pc_q[ADDR_W+1:2];
  assign Instr       = instr_q;
  assign Instr_valid = vld_q;
  assign PC          = pc_q;
  assign Fetch_busy  = busy_q;
`ifdef FETCH_TIMEOUT_EN
  assign Fetch_err   = err_q;
`else
  assign Fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ifstage_fetch_unit.sv
// Bench for ifstage_fetch_unit: directed PC sequences against a req/ack memory model,
// fetched words checked by a scoreboard monitor on each Instr_valid rise.
module tb_ifstage_fetch_unit;
  localparam int ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [31:0]       PC_Immed = '0;
  logic              PC_sel = 1'b0;
  logic              PC_LdEn = 1'b0;
  logic              IMem_Req;
  logic [ADDR_W-1:0] IMem_Addr;
  logic              IMem_Ack = 1'b0;
  logic [31:0]       IMem_RdData = '0;
  logic [31:0]       Instr;
  logic              Instr_valid;
  logic [31:0]       PC;
  logic              Fetch_busy;
  logic              Fetch_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  int   mem_lat   = 1;
  bit   mem_en    = 1'b1;
  bit   mem_force = 1'b0;
  int   wait_cnt  = 0;
  logic prev_v    = 1'b0;

  typedef struct {
    logic        sel;
    logic [31:0] imm;
    logic [31:0] exp_pc;
  } step_t;

  ifstage_fetch_unit #(
    .ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000), .TIMEOUT_CYC(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .PC_Immed(PC_Immed), .PC_sel(PC_sel), .PC_LdEn(PC_LdEn),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ack(IMem_Ack), .IMem_RdData(IMem_RdData),
    .Instr(Instr), .Instr_valid(Instr_valid), .PC(PC), .Fetch_busy(Fetch_busy), .Fetch_err(Fetch_err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memword(input logic [ADDR_W-1:0] a);
    if (a == '0) return 32'h2001_0005;
    return 32'hA500_0000 | {22'd0, a};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < maxc && !seen) begin
      @(negedge Clk);
      if (Instr_valid) seen = 1'b1;
      n++;
    end
    if (!seen) chk("valid_timeout", 32'(Instr_valid), 32'd1);
  endtask

  // Issue PC_LdEn from HOLD; inputs are scrambled afterwards so late sampling shows up.
  task automatic advance(input logic sel, input logic [31:0] imm, input logic [31:0] exp_pc);
    tick();
    PC_LdEn  = 1'b1;
    PC_sel   = sel;
    PC_Immed = imm;
    exp_q.push_back(mk(exp_pc, memword(exp_pc[ADDR_W+1:2])));
    tick();
    PC_LdEn  = 1'b0;
    PC_sel   = 1'b1;
    PC_Immed = 32'h0000_0123;
    @(negedge Clk);
    chk("adv_pc", PC, exp_pc);
    chk("adv_addr", 32'(IMem_Addr), 32'(exp_pc[ADDR_W+1:2]));
    chk("adv_req", 32'(IMem_Req), 32'd1);
    chk("adv_vld_low", 32'(Instr_valid), 32'd0);
    wait_valid(8);
  endtask

  // Memory model: ack on the mem_lat-th cycle of a request.
  initial begin
    forever begin
      @(negedge Clk);
      if (mem_force) begin
        IMem_Ack    = 1'b1;
        IMem_RdData = 32'hDEAD_BEEF;
      end else if (IMem_Req && mem_en) begin
        if (wait_cnt >= mem_lat - 1) begin
          IMem_Ack    = 1'b1;
          IMem_RdData = memword(IMem_Addr);
          wait_cnt    = 0;
        end else begin
          IMem_Ack    = 1'b0;
          IMem_RdData = 32'hBAD0_BAD0;
          wait_cnt++;
        end
      end else begin
        IMem_Ack    = 1'b0;
        IMem_RdData = 32'hBAD0_BAD0;
        wait_cnt    = 0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Instr_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", Instr, e.instr);
          chk("sb_pc", PC, e.pc);
        end
      end
      prev_v = Instr_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    step_t steps[14];
    int reqc;
    steps = '{
      '{1'b0, 32'h0, 32'h04}, '{1'b0, 32'h0, 32'h08}, '{1'b0, 32'h0, 32'h0C},
      '{1'b0, 32'h0, 32'h10}, '{1'b0, 32'h0, 32'h14}, '{1'b0, 32'h0, 32'h18},
      '{1'b0, 32'h0, 32'h1C}, '{1'b0, 32'h0, 32'h20},
      '{1'b1, 32'hFFFF_FFFE, 32'h1C}, '{1'b0, 32'h0, 32'h20},
      '{1'b1, 32'h0000_0003, 32'h30}, '{1'b1, 32'h4000_0001, 32'h38},
      '{1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFC}, '{1'b0, 32'h0, 32'h0}
    };

    Reset = 1'b1;
    repeat (3) tick();
    @(negedge Clk);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_vld", 32'(Instr_valid), 32'd0);
    chk("rst_req", 32'(IMem_Req), 32'd0);
    chk("rst_busy", 32'(Fetch_busy), 32'd1);
    chk("rst_err", 32'(Fetch_err), 32'd0);

    exp_q.push_back(mk(32'h0, 32'h2001_0005));
    tick();
    Reset = 1'b0;
    tick();
    @(negedge Clk);
    chk("c1_req", 32'(IMem_Req), 32'd1);
    chk("c1_addr", 32'(IMem_Addr), 32'd0);
    chk("c1_vld", 32'(Instr_valid), 32'd0);
    chk("c1_busy", 32'(Fetch_busy), 32'd1);
    @(negedge Clk);
    chk("c2_vld", 32'(Instr_valid), 32'd1);
    chk("c2_req", 32'(IMem_Req), 32'd0);
    chk("c2_busy", 32'(Fetch_busy), 32'd0);

    PC_sel   = 1'b1;
    PC_Immed = 32'h0000_0040;
    repeat (3) @(negedge Clk);
    chk("hold_pc", PC, 32'h0);
    chk("hold_vld", 32'(Instr_valid), 32'd1);
    chk("hold_req", 32'(IMem_Req), 32'd0);
    chk("hold_instr", Instr, 32'h2001_0005);

    foreach (steps[i]) advance(steps[i].sel, steps[i].imm, steps[i].exp_pc);

    // Slow memory; PC_LdEn pulse during REQ must be ignored.
    mem_lat = 3;
    tick();
    PC_LdEn = 1'b1;
    PC_sel  = 1'b0;
    exp_q.push_back(mk(32'h4, memword(10'd1)));
    tick();
    PC_LdEn  = 1'b1;
    PC_sel   = 1'b1;
    PC_Immed = 32'h5;
    @(negedge Clk);
    chk("slow1_pc", PC, 32'h4);
    chk("slow1_req", 32'(IMem_Req), 32'd1);
    chk("slow1_addr", 32'(IMem_Addr), 32'd1);
    chk("slow1_instr_old", Instr, 32'h2001_0005);
    tick();
    PC_LdEn  = 1'b0;
    PC_sel   = 1'b0;
    PC_Immed = 32'h0;
    @(negedge Clk);
    chk("slow2_pc", PC, 32'h4);
    chk("slow2_req", 32'(IMem_Req), 32'd1);
    chk("slow2_addr", 32'(IMem_Addr), 32'd1);
    @(negedge Clk);
    chk("slow3_req", 32'(IMem_Req), 32'd1);
    chk("slow3_vld", 32'(Instr_valid), 32'd0);
    chk("slow3_instr_old", Instr, 32'h2001_0005);
    @(negedge Clk);
    chk("slow4_vld", 32'(Instr_valid), 32'd1);
    chk("slow4_req", 32'(IMem_Req), 32'd0);
    chk("slow4_pc", PC, 32'h4);
    mem_lat = 1;

    // Reset lands on the same edge as an ack, then a late ack arrives in IDLE.
    tick();
    PC_LdEn = 1'b1;
    tick();
    PC_LdEn = 1'b0;
    Reset   = 1'b1;
    @(negedge Clk);
    chk("rr_req", 32'(IMem_Req), 32'd1);
    chk("rr_pc", PC, 32'h8);
    tick();
    mem_force = 1'b1;
    @(negedge Clk);
    chk("rr_instr", Instr, 32'h0);
    chk("rr_vld", 32'(Instr_valid), 32'd0);
    chk("rr_pc0", PC, 32'h0);
    chk("rr_req0", 32'(IMem_Req), 32'd0);
    chk("rr_busy", 32'(Fetch_busy), 32'd1);
    tick();
    Reset = 1'b0;
    tick();
    mem_force = 1'b0;
    exp_q.push_back(mk(32'h0, 32'h2001_0005));
    @(negedge Clk);
    chk("idle_ack_instr", Instr, 32'h0);
    chk("idle_ack_vld", 32'(Instr_valid), 32'd0);
    chk("idle_ack_req", 32'(IMem_Req), 32'd1);
    wait_valid(8);

`ifdef FETCH_TIMEOUT_EN
    mem_en = 1'b0;
    tick();
    PC_LdEn = 1'b1;
    exp_q.push_back(mk(32'h4, 32'h0));
    tick();
    PC_LdEn = 1'b0;
    reqc = 0;
    for (int n = 0; n < 40 && !Instr_valid; n++) begin
      @(negedge Clk);
      if (IMem_Req) reqc++;
    end
    chk("tmo_req_cycles", 32'(reqc), 32'd16);
    chk("tmo_err", 32'(Fetch_err), 32'd1);
    chk("tmo_vld", 32'(Instr_valid), 32'd1);
    mem_en = 1'b1;
    advance(1'b0, 32'h0, 32'h8);
    chk("tmo_err_sticky", 32'(Fetch_err), 32'd1);
    tick();
    Reset = 1'b1;
    exp_q.push_back(mk(32'h0, 32'h2001_0005));
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    chk("tmo_err_cleared", 32'(Fetch_err), 32'd0);
    wait_valid(8);
`else
    reqc = 0;
    chk("err_tied", 32'(Fetch_err), 32'(reqc));
`endif

    repeat (3) @(negedge Clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifstage_fetch_unit.md
Name: ifstage_fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the decode stage; owns the program counter and drives the 32-bit Instr word that decode consumes. Issues word reads to instruction memory over a req/ack handshake, holds the fetched word stable until the control unit advances the PC, and computes sequential (PC+4) or branch (PC+4+Immed*4) next-PC. Branch immediate comes back from decode's sign-extended Immed output.

Parameters:
ADDR_W, 10, instruction memory word-address width (IMem_Addr = PC[ADDR_W+1:2])
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
TIMEOUT_CYC, 16, ack watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)

Ports:
Clk  input  1  single clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
PC_Immed  input  32  sign-extended word offset from decode Immed
PC_sel  input  1  0: next PC = PC+4; 1: next PC = PC+4+(PC_Immed<<2)
PC_LdEn  input  1  advance PC and start next fetch (honoured only in HOLD)
IMem_Req  output  1  read request to instruction memory
IMem_Addr  output  ADDR_W  word address = PC[ADDR_W+1:2]
IMem_Ack  input  1  memory data valid this cycle
IMem_RdData  input  32  instruction word from memory
Instr  output  32  registered instruction to decode
Instr_valid  output  1  Instr holds the word for current PC
PC  output  32  current program counter
Fetch_busy  output  1  high in IDLE/REQ (fetch in flight)
Fetch_err  output  1  sticky watchdog error (0 when macro undefined)

Behaviour:
- Reset (sync, active-high): PC=RESET_PC, Instr=0, Instr_valid=0, IMem_Req=0, Fetch_busy=1, Fetch_err=0, FSM=IDLE. Reset dominates every other input incl. IMem_Ack in same cycle; reset mid-fetch abandons the request (IMem_Req low after the edge), any late ack is ignored in IDLE.
- FSM states: IDLE, REQ, HOLD.
- IDLE: one cycle after reset release -> REQ. IMem_Req=0.
- REQ: IMem_Req=1, IMem_Addr stable = PC[ADDR_W+1:2]; req held until ack. On IMem_Ack=1: Instr<=IMem_RdData, Instr_valid<=1, -> HOLD. Ack in same cycle as req asserted is legal (zero-wait memory).
- HOLD: IMem_Req=0, Instr/Instr_valid/PC stable indefinitely. On PC_LdEn=1: PC<=next PC, Instr_valid<=0, -> REQ. Instr keeps old value while invalid.
- PC_LdEn in IDLE/REQ ignored (no PC change, no queueing). PC_sel/PC_Immed sampled only on the PC_LdEn cycle.
- Latency: reset release at cycle 0 -> IMem_Req at cycle 1; zero-wait ack -> Instr_valid at cycle 2. PC_LdEn in HOLD at cycle n -> IMem_Req at n+1, Instr_valid at n+2 (zero wait).
- Arithmetic: 32-bit modulo-2^32 add; PC_Immed<<2 discards top 2 bits; PC=32'hFFFF_FFFC +4 wraps to 0. PC[1:0] always 00.
- Fetch_busy = (state != HOLD).

Optional Feature:
FETCH_TIMEOUT_EN: when defined, a counter clears on entering REQ and increments each REQ cycle without ack; on reaching TIMEOUT_CYC, Fetch_err<=1 (sticky until Reset), Instr<=32'h0000_0000 (NOP), Instr_valid<=1, -> HOLD, so decode never stalls forever. Undefined: no counter, REQ waits indefinitely, Fetch_err tied 0.

Test Plan:
Reset release, zero-wait memory returning 32'h2001_0005 at addr 0 -> IMem_Req at cycle 1, Instr=32'h2001_0005, Instr_valid=1 at cycle 2, PC=0.
HOLD, PC_LdEn=1, PC_sel=0 from PC=0x10 -> PC=0x14, IMem_Addr=5, Instr_valid low one cycle, new word latched.
HOLD at PC=0x20, PC_sel=1, PC_Immed=32'hFFFF_FFFE -> PC=0x1C; PC_Immed=3 -> PC=0x30.
Memory with 3-cycle ack delay -> IMem_Req high 3 cycles with constant address, Instr updates only on ack; PC_LdEn pulses during REQ -> PC unchanged.
Reset asserted while in REQ with ack in same cycle -> Instr stays 0, Instr_valid=0, PC=RESET_PC.
FETCH_TIMEOUT_EN defined, ack never returns -> after 16 REQ cycles Fetch_err=1, Instr=0, Instr_valid=1; stays 1 after next successful fetch until Reset.
